fetch_controller: RTL and testbench

- Instruction-fetch sequencer in front of the combinational instruction memory.
- Owns the program counter and drives the byte address to memory each cycle.
- Captures the returned 32-bit word with its PC into a small prefetch FIFO.
- Presents FIFO entries to decode over a valid/ready handshake; handles branch/jump redirects by flushing and re-steering the PC.

---
 rtl/fetch_controller_if.sv | 52 +++++
 rtl/fetch_controller.sv | 195 +++++++++++++++++++
 tb/tb_fetch_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// -----------------------------------------------------------------------------
// fetch_controller_if
// Bus bundle between the fetch sequencer and its neighbours: the instruction
// memory request/response, the branch redirect input and the decode-side
// valid/ready instruction stream.
//   master : the fetch controller (drives imem_addr and inst_*)
//   slave  : memory/decode environment (drives imem_rdata, redirect_*, inst_ready)
// Signals:
//   imem_addr      byte address to instruction memory
//   imem_rdata     instruction word, valid in the same cycle as imem_addr
//   redirect_valid one-cycle branch/jump pulse
//   redirect_pc    new fetch target
//   inst_valid     head of prefetch FIFO is valid
//   inst_ready     decode accepts the head
//   inst_data      head instruction word
//   inst_pc        PC of the head instruction
// -----------------------------------------------------------------------------
interface fetch_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
// Instruction-fetch sequencer. Owns the PC, addresses a combinational
// instruction memory, buffers {pc, word} pairs in a small prefetch FIFO and
// hands them to decode over valid/ready. A redirect flushes the FIFO and
// re-steers the PC to the word-aligned target.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   fetch_en       permit new fetches (low freezes the PC, FIFO still drains)
//   bus            fetch_controller_if.master (memory, redirect, decode stream)
// Optional build macro FETCH_PERF_EN adds:
//   perf_fetch_cnt  pushes into the FIFO (wraps at 2^32)
//   perf_stall_cnt  cycles with fetch_en high while in FULL (wraps at 2^32)
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_en,
  fetch_controller_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [ADDR_WIDTH-1:0] pc_mem_r   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [FIFO_DEPTH];
  logic                  inst_valid_r;
  logic [DATA_WIDTH-1:0] inst_data_r;
  logic [ADDR_WIDTH-1:0] inst_pc_r;

  logic                  pop_s;
  logic                  push_s;
  logic [CNT_W-1:0]      count_next_s;
  logic [PTR_W-1:0]      rd_next_s;
  logic [PTR_W-1:0]      wr_next_s;
  logic [ADDR_WIDTH-1:0] fetch_pc_next_s;
  logic                  head_valid_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [ADDR_WIDTH-1:0] head_pc_s;
  state_t                state_next_s;

  // Redirect targets are forced word-aligned, so the two low bits are dropped.
  logic redirect_lsb_unused_s;
  assign redirect_lsb_unused_s = ^bus.redirect_pc[1:0];

  assign bus.imem_addr  = fetch_pc_r;
  assign bus.inst_valid = inst_valid_r;
  assign bus.inst_data  = inst_data_r;
  assign bus.inst_pc    = inst_pc_r;

  // Next-state computation: handshake, FIFO bookkeeping, next head and FSM.
  always_comb begin
    pop_s           = inst_valid_r & bus.inst_ready & ~bus.redirect_valid;
    push_s          = fetch_en & ~bus.redirect_valid & ((count_r < DEPTH_CNT) | pop_s);
    count_next_s    = count_r;
    rd_next_s       = rd_ptr_r;
    wr_next_s       = wr_ptr_r;
    fetch_pc_next_s = fetch_pc_r;
    head_valid_s    = 1'b0;
    head_data_s     = '0;
    head_pc_s       = '0;
    state_next_s    = state_r;

    if (bus.redirect_valid) begin
      count_next_s    = '0;
      rd_next_s       = '0;
      wr_next_s       = '0;
      fetch_pc_next_s = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CNT_W'(1);
        2'b01:   count_next_s = count_r - CNT_W'(1);
        default: count_next_s = count_r;
      endcase
      if (pop_s) begin
        rd_next_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_next_s = rd_ptr_r;
      end
      if (push_s) begin
        wr_next_s       = wr_ptr_r + PTR_W'(1);
        fetch_pc_next_s = fetch_pc_r + PC_STEP;
      end else begin
        wr_next_s       = wr_ptr_r;
        fetch_pc_next_s = fetch_pc_r;
      end
    end

    // The next head is either an older entry or the word being written this
    // cycle (FIFO empty, or the only entry is popped while pushing).
    if (bus.redirect_valid || (count_next_s == CNT_W'(0))) begin
      head_valid_s = 1'b0;
      head_data_s  = '0;
      head_pc_s    = '0;
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_valid_s = 1'b1;
      head_data_s  = bus.imem_rdata;
      head_pc_s    = fetch_pc_r;
    end else begin
      head_valid_s = 1'b1;
      head_data_s  = data_mem_r[rd_next_s];
      head_pc_s    = pc_mem_r[rd_next_s];
    end

    if (bus.redirect_valid) begin
      state_next_s = fetch_en ? FETCH : IDLE;
    end else if (!fetch_en) begin
      state_next_s = IDLE;
    end else if ((count_next_s == DEPTH_CNT) && !pop_s) begin
      state_next_s = FULL;
    end else begin
      state_next_s = FETCH;
    end
  end

  // Control state, PC, pointers, FSM and registered decode-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      fetch_pc_r   <= RESET_PC;
      count_r      <= '0;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      inst_valid_r <= 1'b0;
      inst_data_r  <= '0;
      inst_pc_r    <= '0;
    end else begin
      state_r      <= state_next_s;
      fetch_pc_r   <= fetch_pc_next_s;
      count_r      <= count_next_s;
      rd_ptr_r     <= rd_next_s;
      wr_ptr_r     <= wr_next_s;
      inst_valid_r <= head_valid_s;
      inst_data_r  <= head_data_s;
      inst_pc_r    <= head_pc_s;
    end
  end

  // FIFO storage; entries are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      data_mem_r[wr_ptr_r] <= bus.imem_rdata;
      pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
    end else begin
      data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
      pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: pushes and fetch-enabled cycles spent in FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (push_s) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end else begin
        perf_fetch_cnt <= perf_fetch_cnt;
      end
      if (fetch_en && (state_r == FULL)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
// Directed bench for fetch_controller. Instance a uses RESET_PC = 0, instance b
// uses RESET_PC = 0xFFFF_FFF8 to exercise PC wrap. Memory contents:
//   word 0 -> 0x0000_0013, word 1 -> 0x0010_0093,
//   any other byte address A -> 0xA000_0000 ^ A.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

  logic clk;
  logic rst;
  logic rst_b;
  logic fetch_en;
  logic fetch_en_b;
  int   total;
  int   bad;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_a;
  logic [31:0] perf_stall_a;
  logic [31:0] perf_fetch_b;
  logic [31:0] perf_stall_b;
`endif

  fetch_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  fetch_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] aligned;
    aligned = {addr[31:2], 2'b00};
    if (aligned == 32'h0000_0000) begin
      return 32'h0000_0013;
    end else if (aligned == 32'h0000_0004) begin
      return 32'h0010_0093;
    end else begin
      return 32'hA000_0000 ^ aligned;
    end
  endfunction

  assign bus_a.imem_rdata = mem_word(bus_a.imem_addr);
  assign bus_b.imem_rdata = mem_word(bus_b.imem_addr);

  fetch_controller #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .fetch_en (fetch_en),
    .bus      (bus_a)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_a),
    .perf_stall_cnt (perf_stall_a)
`endif
  );

  fetch_controller #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)
  ) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .fetch_en (fetch_en_b),
    .bus      (bus_b)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_b),
    .perf_stall_cnt (perf_stall_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst        = 1'b1;
    rst_b      = 1'b1;
    fetch_en   = 1'b0;
    fetch_en_b = 1'b0;
    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_pc    = 32'h0;
    bus_a.inst_ready     = 1'b0;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc    = 32'h0;
    bus_b.inst_ready     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_valid", {31'd0, bus_a.inst_valid}, 32'd0);
    chk("rst_addr",  bus_a.imem_addr, 32'h0000_0000);
    chk("rst_data",  bus_a.inst_data, 32'h0);
    chk("rst_pc",    bus_a.inst_pc,   32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_a, 32'd0);
    chk("rst_perf_stall", perf_stall_a, 32'd0);
`endif

    // Streaming after reset: first instruction on the 2nd cycle
    rst = 1'b0;
    fetch_en = 1'b1;
    bus_a.inst_ready = 1'b1;
    chk("pre_first_valid", {31'd0, bus_a.inst_valid}, 32'd0);
    step();
    chk("first_valid", {31'd0, bus_a.inst_valid}, 32'd1);
    chk("first_pc",    bus_a.inst_pc,   32'h0000_0000);
    chk("first_data",  bus_a.inst_data, 32'h0000_0013);
    step();
    chk("second_pc",   bus_a.inst_pc,   32'h0000_0004);
    chk("second_data", bus_a.inst_data, 32'h0010_0093);
    step();
    chk("third_pc",    bus_a.inst_pc,   32'h0000_0008);
    chk("third_data",  bus_a.inst_data, 32'hA000_0008);

    // Back-pressure: ready low for 5 cycles fills the FIFO
    rst = 1'b1;
    step();
    rst = 1'b0;
    fetch_en = 1'b1;
    bus_a.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, bus_a.inst_valid}, 32'd1);
      chk("stall_pc",    bus_a.inst_pc,   32'h0000_0000);
      chk("stall_data",  bus_a.inst_data, 32'h0000_0013);
    end
    chk("stall_addr", bus_a.imem_addr, 32'h0000_0008);
    bus_a.inst_ready = 1'b1;
    step();
    chk("drain_pc4", bus_a.inst_pc, 32'h0000_0004);
    step();
    chk("drain_pc8", bus_a.inst_pc, 32'h0000_0008);
    chk("drain_data8", bus_a.inst_data, 32'hA000_0008);
    step();
    chk("drain_pc12", bus_a.inst_pc, 32'h0000_000C);

    // Redirect while full
    bus_a.inst_ready = 1'b0;
    step();
    chk("full_head_pc", bus_a.inst_pc, 32'h0000_000C);
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 32'h0000_0043;
    bus_a.inst_ready     = 1'b1;
    step();
    bus_a.redirect_valid = 1'b0;
    chk("redir_valid", {31'd0, bus_a.inst_valid}, 32'd0);
    chk("redir_addr",  bus_a.imem_addr, 32'h0000_0040);
    step();
    chk("redir_head_valid", {31'd0, bus_a.inst_valid}, 32'd1);
    chk("redir_head_pc",    bus_a.inst_pc,   32'h0000_0040);
    chk("redir_head_data",  bus_a.inst_data, 32'hA000_0040);

    // fetch_en dropped with two entries buffered
    bus_a.inst_ready = 1'b0;
    step();
    chk("buf2_head_pc", bus_a.inst_pc, 32'h0000_0040);
    chk("buf2_addr",    bus_a.imem_addr, 32'h0000_0048);
    fetch_en = 1'b0;
    bus_a.inst_ready = 1'b1;
    step();
    chk("pause_pc",   bus_a.inst_pc,   32'h0000_0044);
    chk("pause_data", bus_a.inst_data, 32'hA000_0044);
    chk("pause_addr", bus_a.imem_addr, 32'h0000_0048);
    step();
    chk("pause_empty", {31'd0, bus_a.inst_valid}, 32'd0);
    chk("pause_addr2", bus_a.imem_addr, 32'h0000_0048);
    step();
    chk("pause_empty2", {31'd0, bus_a.inst_valid}, 32'd0);
    chk("pause_zero_pc", bus_a.inst_pc, 32'h0);
    chk("pause_addr3", bus_a.imem_addr, 32'h0000_0048);

    // Reset mid-stream with two entries buffered
    fetch_en = 1'b1;
    bus_a.inst_ready = 1'b0;
    step();
    step();
    chk("pre_rst_valid", {31'd0, bus_a.inst_valid}, 32'd1);
    chk("pre_rst_addr",  bus_a.imem_addr, 32'h0000_0050);
`ifdef FETCH_PERF_EN
    chk("pre_rst_perf_fetch", perf_fetch_a, 32'd9);
`endif
    rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'd0, bus_a.inst_valid}, 32'd0);
    chk("mid_rst_addr",  bus_a.imem_addr, 32'h0000_0000);
`ifdef FETCH_PERF_EN
    chk("mid_rst_perf_fetch", perf_fetch_a, 32'd0);
    chk("mid_rst_perf_stall", perf_stall_a, 32'd0);
`endif

    // PC wrap on instance b
    rst_b = 1'b0;
    fetch_en_b = 1'b1;
    bus_b.inst_ready = 1'b1;
    step();
    chk("wrap_pc0",   bus_b.inst_pc,   32'hFFFF_FFF8);
    chk("wrap_data0", bus_b.inst_data, 32'h5FFF_FFF8);
    step();
    chk("wrap_pc1",   bus_b.inst_pc,   32'hFFFF_FFFC);
    chk("wrap_data1", bus_b.inst_data, 32'h5FFF_FFFC);
    step();
    chk("wrap_pc2",   bus_b.inst_pc,   32'h0000_0000);
    chk("wrap_data2", bus_b.inst_data, 32'h0000_0013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
